// File: rtl/taxi_axis_mcast_sched_if.sv
// taxi_axis_if: AXI4-Stream signal bundle shared by the multicast scheduler and its bench.
// Parameters select the optional sideband fields. Disabled fields are still present as
// signals so that widths stay legal, but consumers replace them with their default values.
// Modports:
//   src - stream source (drives payload and tvalid, samples tready)
//   snk - stream sink   (samples payload and tvalid, drives tready)
interface taxi_axis_if #(
   parameter int DATA_W  = 8,
   parameter int KEEP_EN = (DATA_W > 8) ? 1 : 0,
   parameter int KEEP_W  = (DATA_W + 7) / 8,
   parameter int STRB_EN = 0,
   parameter int LAST_EN = 1,
   parameter int ID_EN   = 0,
   parameter int ID_W    = 8,
   parameter int DEST_EN = 0,
   parameter int DEST_W  = 8,
   parameter int USER_EN = 0,
   parameter int USER_W  = 1
) ();
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic [KEEP_W-1:0] tstrb;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [ID_W-1:0]   tid;
   logic [DEST_W-1:0] tdest;
   logic [USER_W-1:0] tuser;

   modport src (
      output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
      input  tready
   );

   modport snk (
      input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
      output tready
   );
endinterface

// File: rtl/taxi_axis_mcast_sched.sv
// taxi_axis_mcast_sched: frame-level multicast of one AXI4-Stream source to M_COUNT sinks.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axis                input stream (sink side)
//   s_mask, cfg_port_en   destination mask and port enable, sampled on a frame's first beat
//   m_axis[M_COUNT]       output streams, all driven from one shared beat register
//   stat_frames           forwarded-frame counter (wraps)
//   stat_drops            dropped-frame counter (wraps)
//   busy                  mid-frame or a beat still waiting for some sink
module taxi_axis_mcast_sched #(
   parameter int M_COUNT = 4,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   taxi_axis_if.snk           s_axis,
   input  logic [M_COUNT-1:0] s_mask,
   input  logic [M_COUNT-1:0] cfg_port_en,
   taxi_axis_if.src           m_axis [M_COUNT],
   output logic [CNT_W-1:0]   stat_frames,
   output logic [CNT_W-1:0]   stat_drops,
   output logic               busy
);
   localparam int DATA_W  = s_axis.DATA_W;
   localparam int KEEP_EN = s_axis.KEEP_EN;
   localparam int KEEP_W  = s_axis.KEEP_W;
   localparam int STRB_EN = s_axis.STRB_EN;
   localparam int LAST_EN = s_axis.LAST_EN;
   localparam int ID_EN   = s_axis.ID_EN;
   localparam int ID_W    = s_axis.ID_W;
   localparam int DEST_EN = s_axis.DEST_EN;
   localparam int DEST_W  = s_axis.DEST_W;
   localparam int USER_EN = s_axis.USER_EN;
   localparam int USER_W  = s_axis.USER_W;

   typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

   state_t             state, state_nx;
   logic [M_COUNT-1:0] pend, pend_nx;
   logic [M_COUNT-1:0] fmask, fmask_nx;
   logic [M_COUNT-1:0] m_rdy;
   logic [M_COUNT-1:0] eff;
   logic               drain, acc, load, last_in, inc_frame, inc_drop;

   logic [DATA_W-1:0]  data_r;
   logic [KEEP_W-1:0]  keep_r, strb_r;
   logic               last_r;
   logic [ID_W-1:0]    id_r;
   logic [DEST_W-1:0]  dest_r;
   logic [USER_W-1:0]  user_r;

   logic [KEEP_W-1:0]  keep_in, strb_in;
   logic [ID_W-1:0]    id_in;
   logic [DEST_W-1:0]  dest_in;
   logic [USER_W-1:0]  user_in;

   // Disabled sideband fields take their stream defaults before being registered.
   assign keep_in = (KEEP_EN != 0) ? s_axis.tkeep : '1;
   assign strb_in = (STRB_EN != 0) ? s_axis.tstrb : keep_in;
   assign last_in = (LAST_EN != 0) ? s_axis.tlast : 1'b1;
   assign id_in   = (ID_EN != 0)   ? s_axis.tid   : '0;
   assign dest_in = (DEST_EN != 0) ? s_axis.tdest : '0;
   assign user_in = (USER_EN != 0) ? s_axis.tuser : '0;

   assign eff = s_mask & cfg_port_en;

   // The shared register empties this cycle when every still-pending sink is ready,
   // so a new beat can be loaded in the same cycle (full throughput).
   assign drain = (pend & ~m_rdy) == '0;

   // A dropped frame never touches the register, so it is consumed regardless of pend.
   assign s_axis.tready = rst_n && (state == DROP || drain);
   assign acc = s_axis.tvalid && s_axis.tready;

   assign busy = (state != IDLE) || (pend != '0);

   always_comb begin
      state_nx  = state;
      fmask_nx  = fmask;
      pend_nx   = pend & ~m_rdy;
      load      = 1'b0;
      inc_frame = 1'b0;
      inc_drop  = 1'b0;
      if (acc) begin
         case (state)
            IDLE: begin
               if (eff != '0) begin
                  load      = 1'b1;
                  pend_nx   = eff;
                  fmask_nx  = eff;
                  inc_frame = last_in;
                  state_nx  = last_in ? IDLE : FWD;
               end else begin
                  inc_drop = last_in;
                  state_nx = last_in ? IDLE : DROP;
               end
            end
            FWD: begin
               load      = 1'b1;
               pend_nx   = fmask;
               inc_frame = last_in;
               state_nx  = last_in ? IDLE : FWD;
            end
            DROP: begin
               inc_drop = last_in;
               state_nx = last_in ? IDLE : DROP;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pend        <= '0;
         fmask       <= '0;
         stat_frames <= '0;
         stat_drops  <= '0;
         data_r      <= '0;
         keep_r      <= '0;
         strb_r      <= '0;
         last_r      <= 1'b0;
         id_r        <= '0;
         dest_r      <= '0;
         user_r      <= '0;
      end else begin
         state       <= state_nx;
         pend        <= pend_nx;
         fmask       <= fmask_nx;
         stat_frames <= stat_frames + CNT_W'(inc_frame);
         stat_drops  <= stat_drops + CNT_W'(inc_drop);
         if (load) begin
            data_r <= s_axis.tdata;
            keep_r <= keep_in;
            strb_r <= strb_in;
            last_r <= last_in;
            id_r   <= id_in;
            dest_r <= dest_in;
            user_r <= user_in;
         end
      end
   end

   for (genvar g = 0; g < M_COUNT; g++) begin : g_out
      assign m_rdy[g]         = m_axis[g].tready;
      assign m_axis[g].tvalid = pend[g];
      assign m_axis[g].tdata  = data_r;
      assign m_axis[g].tkeep  = keep_r;
      assign m_axis[g].tstrb  = strb_r;
      assign m_axis[g].tlast  = last_r;
      assign m_axis[g].tid    = id_r;
      assign m_axis[g].tdest  = dest_r;
      assign m_axis[g].tuser  = user_r;
   end
endmodule

// File: tb/tb_taxi_axis_mcast_sched.sv
// tb_taxi_axis_mcast_sched: directed plus randomized bench against a frame-level queue model.
// Ports: none (top-level bench).
module tb_taxi_axis_mcast_sched;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    s_mask = '0;
   logic [3:0]    cfg = 4'hf;
   logic [CW-1:0] stat_frames, stat_drops;
   logic          busy;

   logic [3:0]    m_rdy = 4'hf, man_rdy = 4'hf, m_val, m_last, m_keep, m_strb;
   logic [7:0]    m_dat [4];
   int            rdy_mode = 0;

   int checks = 0, errors = 0;

   // Model: one queue per output of beats not yet taken, plus frame-level state.
   logic [8:0] q [4][$];
   bit         in_frame = 0;
   logic [3:0] fmask = '0;
   int         mdl_frames = 0, mdl_drops = 0;
   int         rx_cnt [4] = '{0, 0, 0, 0};

   taxi_axis_if #(.DATA_W(8)) s_axis ();
   taxi_axis_if #(.DATA_W(8)) m_axis [4] ();

   taxi_axis_mcast_sched #(.M_COUNT(4), .CNT_W(CW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_axis(s_axis),
      .s_mask(s_mask),
      .cfg_port_en(cfg),
      .m_axis(m_axis),
      .stat_frames(stat_frames),
      .stat_drops(stat_drops),
      .busy(busy)
   );

   for (genvar g = 0; g < 4; g++) begin : g_m
      assign m_axis[g].tready = m_rdy[g];
      assign m_val[g]  = m_axis[g].tvalid;
      assign m_last[g] = m_axis[g].tlast;
      assign m_keep[g] = m_axis[g].tkeep[0];
      assign m_strb[g] = m_axis[g].tstrb[0];
      assign m_dat[g]  = m_axis[g].tdata;
   end

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0) m_rdy = 4'hf;
      else if (rdy_mode == 1) for (int n = 0; n < 4; n++) m_rdy[n] = ($urandom_range(0, 3) != 0);
      else m_rdy = man_rdy;
   end

   // Compare against the model, then advance it by the handshakes of the coming edge.
   always @(negedge clk) begin
      logic [3:0] pm, m;
      if (!rst_n) begin
         chk("rst_s_tready", s_axis.tready, 0);
         chk("rst_tvalid", m_val, 0);
         chk("rst_frames", stat_frames, 0);
         chk("rst_drops", stat_drops, 0);
         chk("rst_busy", busy, 0);
         for (int n = 0; n < 4; n++) q[n].delete();
         in_frame = 0;
         fmask = '0;
         mdl_frames = 0;
         mdl_drops = 0;
      end else begin
         for (int n = 0; n < 4; n++) begin
            pm[n] = q[n].size() != 0;
            chk($sformatf("tvalid%0d", n), m_val[n], pm[n]);
            if (pm[n] && m_val[n]) begin
               chk($sformatf("beat%0d", n), {m_last[n], m_dat[n]}, q[n][0]);
               chk($sformatf("keep%0d", n), {m_strb[n], m_keep[n]}, 2'b11);
            end
         end
         chk("s_tready", s_axis.tready, (in_frame && fmask == 0) || ((pm & ~m_rdy) == 0));
         chk("frames", stat_frames, mdl_frames % (1 << CW));
         chk("drops", stat_drops, mdl_drops % (1 << CW));
         chk("busy", busy, in_frame || pm != 0);
         for (int n = 0; n < 4; n++)
            if (m_val[n] && m_rdy[n] && q[n].size() != 0) begin
               void'(q[n].pop_front());
               rx_cnt[n]++;
            end
         if (s_axis.tvalid && s_axis.tready) begin
            m = in_frame ? fmask : (s_mask & cfg);
            for (int n = 0; n < 4; n++) if (m[n]) q[n].push_back({s_axis.tlast, s_axis.tdata});
            if (s_axis.tlast) begin
               if (m != 0) mdl_frames++;
               else mdl_drops++;
               in_frame = 0;
            end else begin
               in_frame = 1;
               fmask = m;
            end
         end
      end
   end

   task automatic send(input int len, input logic [3:0] mask, input bit gaps,
                       input logic [3:0] cfg1, output int cyc);
      bit hs;
      cyc = 0;
      for (int i = 0; i < len; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin
            s_axis.tvalid = 1'b0;
            @(posedge clk); #1;
         end
         s_axis.tvalid = 1'b1;
         s_axis.tdata  = 8'($urandom);
         s_axis.tlast  = (i == len - 1);
         s_mask        = (i == 0) ? mask : 4'($urandom);
         hs = 0;
         while (!hs) begin
            @(negedge clk);
            hs = s_axis.tready;
            cyc++;
            if (cyc > 2000) begin
               $display("FAIL send_timeout act=%0d exp=<2000", cyc);
               $fatal(1, "stuck");
            end
            @(posedge clk); #1;
         end
         if (i == 0) cfg = cfg1;
      end
      s_axis.tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int c, tot;
      s_axis.tvalid = 1'b0;
      s_axis.tdata  = '0;
      s_axis.tlast  = 1'b0;
      s_axis.tkeep  = '1;
      s_axis.tstrb  = '1;
      s_axis.tid    = '0;
      s_axis.tdest  = '0;
      s_axis.tuser  = '0;
      idle(3);
      rst_n = 1'b1;
      idle(2);
      chk("post_rst_tready", s_axis.tready, 1);
      chk("post_rst_busy", busy, 0);

      send(1, 4'b0101, 0, 4'hf, c);
      idle(3);
      chk("t1_rx", {rx_cnt[3][3:0], rx_cnt[2][3:0], rx_cnt[1][3:0], rx_cnt[0][3:0]}, 16'h0101);
      chk("t1_frames", stat_frames, 1);
      chk("t1_model", mdl_frames, 1);

      rdy_mode = 2;
      man_rdy  = 4'b1101;
      fork
         send(3, 4'b0011, 0, 4'hf, c);
         begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            man_rdy = 4'hf;
         end
      join
      rdy_mode = 0;
      idle(3);
      chk("t2_rx", {rx_cnt[3][3:0], rx_cnt[2][3:0], rx_cnt[1][3:0], rx_cnt[0][3:0]}, 16'h0134);

      cfg = 4'b1100;
      send(4, 4'b0011, 0, 4'b1100, c);
      idle(3);
      chk("t3_cycles", c, 4);
      chk("t3_drops", stat_drops, 1);
      chk("t3_rx", {rx_cnt[3][3:0], rx_cnt[2][3:0], rx_cnt[1][3:0], rx_cnt[0][3:0]}, 16'h0134);

      cfg = 4'hf;
      send(4, 4'hf, 0, 4'b0001, c);
      send(1, 4'hf, 0, 4'b0001, c);
      idle(3);
      chk("t4_rx", {rx_cnt[3][3:0], rx_cnt[2][3:0], rx_cnt[1][3:0], rx_cnt[0][3:0]}, 16'h4579);
      chk("t4_frames", stat_frames, 4);

      cfg = 4'hf;
      tot = 0;
      send(2, 4'hf, 0, 4'hf, c); tot += c;
      send(3, 4'hf, 0, 4'hf, c); tot += c;
      send(1, 4'hf, 0, 4'hf, c); tot += c;
      idle(3);
      chk("t5_cycles", tot, 6);
      chk("t5_frames", stat_frames, 7);

      s_axis.tvalid = 1'b1;
      s_axis.tlast  = 1'b0;
      s_mask        = 4'hf;
      s_axis.tdata  = 8'h11;
      @(posedge clk); #1;
      s_axis.tdata  = 8'h22;
      @(posedge clk); #1;
      rst_n = 1'b0;
      s_axis.tvalid = 1'b0;
      #2;
      chk("t6_rst_tvalid", m_val, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      c = rx_cnt[1];
      send(1, 4'b0010, 0, 4'hf, tot);
      idle(3);
      chk("t6_frames", stat_frames, 1);
      chk("t6_rx1", rx_cnt[1] - c, 1);

      rdy_mode = 1;
      for (int f = 0; f < 300; f++) begin
         cfg = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
         if (f % 50 == 25) rdy_mode = 0;
         if (f % 50 == 40) rdy_mode = 1;
         send($urandom_range(1, 5), 4'($urandom), 1, 4'($urandom), c);
      end
      rdy_mode = 0;
      idle(10);
      chk("end_busy", busy, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
